alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 RESET  input  1  synchronous, active-high reset.
REQ-003 REQ_VALID  input  1  ALU operation request present.
REQ-004 REQ_READY  output  1  request accepted on an edge where REQ_VALID && REQ_READY.
REQ-005 REQ_OPCODE  input  4  ALU opcode, passed unchanged to the ALU.
REQ-006 REQ_SRC_A, REQ_SRC_B  input  2 each  register-file indices of operands A and B.
REQ-007 REQ_DST  input  2  destination register index.
REQ-008 REQ_WB  input  1  1 = write the result to REQ_DST; 0 = discard it (compare-only).
REQ-009 ALU_IN_A, ALU_IN_B  output  8 each  operands driven to the ALU.
REQ-010 ALU_OP_CODE  output  4  opcode driven to the ALU.
REQ-011 ALU_RESULT  input  8  registered ALU output, one cycle after its inputs.
REQ-012 LD_VALID  input  1  external register load request.
REQ-013 LD_READY  output  1  load accepted on an edge where LD_VALID && LD_READY.
REQ-014 LD_ADDR, LD_DATA  input  2 / 8  load target index and data.
REQ-015 DONE  output  1  one-cycle pulse: RESULT_OUT is valid.
REQ-016 RESULT_OUT  output  8  completed result, valid while DONE=1.
REQ-017 RD_ADDR / RD_DATA  input 2 / output 8  combinational debug read of the register file.

Function
REQ-018 The block SHALL contain a register file of 4 x 8-bit registers, R0-R3.
REQ-019 The FSM SHALL have three states: IDLE, ISSUE, WB.
REQ-020 In IDLE, REQ_READY=1; an accepted request latches opcode, dst and wb, reads operands, then moves to ISSUE.
REQ-021 In ISSUE, REQ_READY=0; ALU_IN_A, ALU_IN_B and ALU_OP_CODE come from the latched values; next state is WB.
REQ-022 In WB, DONE=1, RESULT_OUT=ALU_RESULT, and if wb=1, R[dst] <= ALU_RESULT on the closing edge.
REQ-023 In WB, REQ_READY=1; an accepted request goes to ISSUE, otherwise the FSM returns to IDLE.
REQ-024 Latency from the accept edge to DONE high SHALL be 2 cycles; back-to-back throughput SHALL be one operation per 2 cycles.
REQ-025 Forwarding: for a request accepted in WB with wb=1 and a source index equal to the current dst, that operand SHALL be ALU_RESULT, not the stale register.
REQ-026 Outside ISSUE, the ALU outputs SHALL hold their last driven values.
REQ-027 Opcode values SHALL be passed through unchanged; 8-bit results wrap modulo 256, with no overflow indication.
REQ-028 A load SHALL write R[LD_ADDR] <= LD_DATA in any state.
REQ-029 LD_READY SHALL be 0 only when the state is WB, wb=1 and LD_ADDR==dst (writeback wins); LD_READY=1 otherwise.
REQ-030 A load and an operand read of the same register in the same cycle SHALL read the pre-edge value; loads are not forwarded.
REQ-031 An ALU_RESULT arriving while in IDLE SHALL be ignored.

Reset
REQ-032 On RESET: R0-R3 cleared to 0x00, state IDLE, latched opcode/dst/wb cleared, ALU_IN_A/ALU_IN_B/ALU_OP_CODE = 0.
REQ-033 On RESET: DONE=0 and RESULT_OUT=0x00.
REQ-034 RESET asserted in ISSUE or WB SHALL abort the operation: no writeback, no DONE pulse.
REQ-035 RESET SHALL take priority over any simultaneous request or load.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding, the ALU opcode constants 0x0-0xC, REG_W=8 and NREG=4.
REQ-037 The register file SHALL be a sub-module, alu_regfile: two combinational read ports, one debug read port, one write port with writeback-over-load priority.
REQ-038 The bench SHALL instantiate alu_issue together with the existing ALU, sharing CLK and RESET.

Verification
REQ-039 Load R0=0x05 and R1=0x03, issue ADD R0,R1->R2 -> DONE 2 cycles after accept, RESULT_OUT=0x08, RD R2=0x08.
REQ-040 R0=0xFF, R1=0x02: ADD->R3 -> 0x01 (wrap); then SUB R1,R0 wb=0 -> RESULT_OUT=0x03, R3 unchanged.
REQ-041 ADD R0,R1->R2 followed back-to-back by INC-A R2->R2 (opcode 0x5) -> second RESULT_OUT = first result + 1 (forwarding).
REQ-042 During WB of an operation with dst=R2, LD_VALID to R2 -> LD_READY=0 that cycle; on retry next cycle the load writes R2.
REQ-043 RESET asserted in ISSUE -> no DONE pulse, all registers 0x00, REQ_READY=1 the cycle after reset.
REQ-044 Compare ops (opcodes 0x9-0xB) with A=0x10, B=0x20 -> 0x00, 0x00, 0x01.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue block: FSM encoding,
// ALU opcode values and register file geometry.
package alu_issue_pkg;

  localparam int REG_W  = 8;
  localparam int NREG   = 4;
  localparam int REG_AW = 2;
  localparam int OP_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } state_e;

  localparam logic [OP_W-1:0] OP_ADD   = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'h1;
  localparam logic [OP_W-1:0] OP_AND   = 4'h2;
  localparam logic [OP_W-1:0] OP_OR    = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR   = 4'h4;
  localparam logic [OP_W-1:0] OP_INCA  = 4'h5;
  localparam logic [OP_W-1:0] OP_DECA  = 4'h6;
  localparam logic [OP_W-1:0] OP_SHL   = 4'h7;
  localparam logic [OP_W-1:0] OP_SHR   = 4'h8;
  localparam logic [OP_W-1:0] OP_CMPEQ = 4'h9;
  localparam logic [OP_W-1:0] OP_CMPGT = 4'hA;
  localparam logic [OP_W-1:0] OP_CMPLT = 4'hB;
  localparam logic [OP_W-1:0] OP_PASSB = 4'hC;

endpackage

// File: rtl/alu_issue_regfile.sv
// 4 x 8-bit register file: two operand read ports, one debug read port,
// writeback and load writes with writeback winning on the same register.
module alu_regfile
  import alu_issue_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [REG_AW-1:0] rd_a_addr,
  output logic [REG_W-1:0]  rd_a_data,
  input  logic [REG_AW-1:0] rd_b_addr,
  output logic [REG_W-1:0]  rd_b_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [REG_W-1:0]  dbg_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [REG_W-1:0]  wb_data,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [REG_W-1:0]  ld_data
);

  logic [NREG-1:0][REG_W-1:0] regs_q, regs_d;

  // Reads see pre-edge contents; loads are never forwarded.
  assign rd_a_data = regs_q[rd_a_addr];
  assign rd_b_data = regs_q[rd_b_addr];
  assign dbg_data  = regs_q[dbg_addr];

  always_comb begin
    regs_d = regs_q;
    if (ld_en) regs_d[ld_addr] = ld_data;
    // Applied last so a writeback overrides a load to the same register.
    if (wb_en) regs_d[wb_addr] = wb_data;
  end

  always_ff @(posedge CLK) begin
    if (RESET) regs_q <= '0;
    else       regs_q <= regs_d;
  end

endmodule

// File: rtl/alu_issue.sv
// Issue controller for an external registered ALU: reads operands, drives
// the ALU for one cycle, then writes back (IDLE -> ISSUE -> WB).
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [OP_W-1:0]   REQ_OPCODE,
  input  logic [REG_AW-1:0] REQ_SRC_A,
  input  logic [REG_AW-1:0] REQ_SRC_B,
  input  logic [REG_AW-1:0] REQ_DST,
  input  logic              REQ_WB,
  output logic [REG_W-1:0]  ALU_IN_A,
  output logic [REG_W-1:0]  ALU_IN_B,
  output logic [OP_W-1:0]   ALU_OP_CODE,
  input  logic [REG_W-1:0]  ALU_RESULT,
  input  logic              LD_VALID,
  output logic              LD_READY,
  input  logic [REG_AW-1:0] LD_ADDR,
  input  logic [REG_W-1:0]  LD_DATA,
  output logic              DONE,
  output logic [REG_W-1:0]  RESULT_OUT,
  input  logic [REG_AW-1:0] RD_ADDR,
  output logic [REG_W-1:0]  RD_DATA
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic              wb_q, wb_d;
  logic [REG_W-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;

  logic              accept, wb_fire, ld_fire;
  logic [REG_W-1:0]  rd_a_data, rd_b_data;

  alu_regfile u_regfile (
    .CLK       (CLK),
    .RESET     (RESET),
    .rd_a_addr (REQ_SRC_A),
    .rd_a_data (rd_a_data),
    .rd_b_addr (REQ_SRC_B),
    .rd_b_data (rd_b_data),
    .dbg_addr  (RD_ADDR),
    .dbg_data  (RD_DATA),
    .wb_en     (wb_fire),
    .wb_addr   (dst_q),
    .wb_data   (ALU_RESULT),
    .ld_en     (ld_fire),
    .ld_addr   (LD_ADDR),
    .ld_data   (LD_DATA)
  );

  // ALU-facing outputs are the latched operands; they only change on accept.
  assign ALU_IN_A    = alu_a_q;
  assign ALU_IN_B    = alu_b_q;
  assign ALU_OP_CODE = op_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dst_d      = dst_q;
    wb_d       = wb_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    REQ_READY  = (state_q != ST_ISSUE);
    DONE       = (state_q == ST_WB);
    RESULT_OUT = DONE ? ALU_RESULT : '0;
    wb_fire    = DONE && wb_q;
    LD_READY   = !(wb_fire && (LD_ADDR == dst_q));
    ld_fire    = LD_VALID && LD_READY;
    accept     = REQ_VALID && REQ_READY;

    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WB;
      ST_WB:    state_d = accept ? ST_ISSUE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (accept) begin
      op_d  = REQ_OPCODE;
      dst_d = REQ_DST;
      wb_d  = REQ_WB;
      // The register being written back this edge is still stale in the file.
      alu_a_d = (wb_fire && (REQ_SRC_A == dst_q)) ? ALU_RESULT : rd_a_data;
      alu_b_d = (wb_fire && (REQ_SRC_B == dst_q)) ? ALU_RESULT : rd_b_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      dst_q   <= '0;
      wb_q    <= 1'b0;
      alu_a_q <= '0;
      alu_b_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      wb_q    <= wb_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural registered ALU in the loop.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       REQ_VALID, REQ_READY, REQ_WB;
  logic [3:0] REQ_OPCODE, ALU_OP_CODE;
  logic [1:0] REQ_SRC_A, REQ_SRC_B, REQ_DST, LD_ADDR, RD_ADDR;
  logic [7:0] ALU_IN_A, ALU_IN_B, ALU_RESULT, LD_DATA, RESULT_OUT, RD_DATA;
  logic       LD_VALID, LD_READY, DONE;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  alu_issue dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OPCODE(REQ_OPCODE),
    .REQ_SRC_A(REQ_SRC_A), .REQ_SRC_B(REQ_SRC_B), .REQ_DST(REQ_DST), .REQ_WB(REQ_WB),
    .ALU_IN_A(ALU_IN_A), .ALU_IN_B(ALU_IN_B), .ALU_OP_CODE(ALU_OP_CODE),
    .ALU_RESULT(ALU_RESULT),
    .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
    .DONE(DONE), .RESULT_OUT(RESULT_OUT), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA)
  );

  // Stand-in for the existing registered ALU, sharing CLK and RESET.
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_XOR:   return a ^ b;
      OP_INCA:  return a + 8'd1;
      OP_DECA:  return a - 8'd1;
      OP_SHL:   return a << 1;
      OP_SHR:   return a >> 1;
      OP_CMPEQ: return {7'd0, a == b};
      OP_CMPGT: return {7'd0, a > b};
      OP_CMPLT: return {7'd0, a < b};
      OP_PASSB: return b;
      default:  return 8'h00;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) ALU_RESULT <= 8'h00;
    else       ALU_RESULT <= alu_f(ALU_OP_CODE, ALU_IN_A, ALU_IN_B);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [1:0] a, input logic [7:0] d);
    LD_VALID = 1'b1; LD_ADDR = a; LD_DATA = d;
    tick();
    LD_VALID = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
    RD_ADDR = a;
    #1;
    d = RD_DATA;
  endtask

  task automatic drive_req(input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                           input logic [1:0] d, input logic w);
    REQ_VALID = 1'b1; REQ_OPCODE = op; REQ_SRC_A = sa; REQ_SRC_B = sb;
    REQ_DST = d; REQ_WB = w;
  endtask

  // Accept from IDLE, then sample DONE in ISSUE and DONE/RESULT_OUT in WB.
  task automatic issue(input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [1:0] d, input logic w,
                       output logic done_iss, output logic done_wb, output logic [7:0] res);
    drive_req(op, sa, sb, d, w);
    tick();
    REQ_VALID = 1'b0;
    #1;
    done_iss = DONE;
    tick();
    done_wb = DONE;
    res = RESULT_OUT;
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] v;
    RESET = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    #1;
    checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b want 1", REQ_READY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", DONE); end
    checks++; if (RESULT_OUT !== 8'h00) begin errors++; $display("FAIL reset_result got %02h want 00", RESULT_OUT); end
    checks++; if ({ALU_IN_A, ALU_IN_B, ALU_OP_CODE} !== 20'h0) begin errors++; $display("FAIL reset_alu_if got %05h want 00000", {ALU_IN_A, ALU_IN_B, ALU_OP_CODE}); end
    checks++; if (LD_READY !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got %0b want 1", LD_READY); end
    for (int i = 0; i < 4; i++) begin
      read_reg(i[1:0], v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got %02h want 00", i, v); end
    end
  endtask

  task automatic test_add();
    logic di, dw; logic [7:0] r, v;
    do_load(2'd0, 8'h05);
    do_load(2'd1, 8'h03);
    issue(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1, di, dw, r);
    checks++; if (di !== 1'b0) begin errors++; $display("FAIL add_done_early got %0b want 0", di); end
    checks++; if (dw !== 1'b1) begin errors++; $display("FAIL add_done got %0b want 1", dw); end
    checks++; if (r !== 8'h08) begin errors++; $display("FAIL add_result got %02h want 08", r); end
    read_reg(2'd2, v);
    checks++; if (v !== 8'h08) begin errors++; $display("FAIL add_r2 got %02h want 08", v); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL add_done_single got %0b want 0", DONE); end
    checks++; if (ALU_IN_A !== 8'h05 || ALU_IN_B !== 8'h03) begin errors++; $display("FAIL add_alu_hold got %02h/%02h want 05/03", ALU_IN_A, ALU_IN_B); end
  endtask

  task automatic test_wrap_and_nowb();
    logic di, dw; logic [7:0] r, v;
    do_load(2'd0, 8'hFF);
    do_load(2'd1, 8'h02);
    issue(OP_ADD, 2'd0, 2'd1, 2'd3, 1'b1, di, dw, r);
    checks++; if (r !== 8'h01) begin errors++; $display("FAIL wrap_result got %02h want 01", r); end
    read_reg(2'd3, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL wrap_r3 got %02h want 01", v); end
    issue(OP_SUB, 2'd1, 2'd0, 2'd3, 1'b0, di, dw, r);
    checks++; if (dw !== 1'b1 || r !== 8'h03) begin errors++; $display("FAIL sub_result got done=%0b %02h want 1 03", dw, r); end
    read_reg(2'd3, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL sub_nowb_r3 got %02h want 01", v); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    do_load(2'd0, 8'h10);
    do_load(2'd1, 8'h20);
    drive_req(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1);
    tick();
    REQ_VALID = 1'b0;
    tick();
    // In WB of the ADD: present INC-A R2->R2, which must see the forwarded 0x30.
    drive_req(OP_INCA, 2'd2, 2'd2, 2'd2, 1'b1);
    #1;
    checks++; if (DONE !== 1'b1 || RESULT_OUT !== 8'h30) begin errors++; $display("FAIL b2b_first got done=%0b %02h want 1 30", DONE, RESULT_OUT); end
    checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL b2b_ready_wb got %0b want 1", REQ_READY); end
    tick();
    REQ_VALID = 1'b0;
    #1;
    checks++; if (DONE !== 1'b0 || REQ_READY !== 1'b0) begin errors++; $display("FAIL b2b_issue got done=%0b ready=%0b want 0 0", DONE, REQ_READY); end
    checks++; if (ALU_IN_A !== 8'h30) begin errors++; $display("FAIL b2b_fwd_operand got %02h want 30", ALU_IN_A); end
    tick();
    checks++; if (DONE !== 1'b1 || RESULT_OUT !== 8'h31) begin errors++; $display("FAIL b2b_second got done=%0b %02h want 1 31", DONE, RESULT_OUT); end
    tick();
    read_reg(2'd2, v);
    checks++; if (v !== 8'h31) begin errors++; $display("FAIL b2b_r2 got %02h want 31", v); end
  endtask

  task automatic test_ld_conflict();
    logic [7:0] v;
    drive_req(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1);
    tick();
    REQ_VALID = 1'b0;
    tick();
    LD_VALID = 1'b1; LD_ADDR = 2'd2; LD_DATA = 8'hAA;
    #1;
    checks++; if (LD_READY !== 1'b0) begin errors++; $display("FAIL ld_block got %0b want 0", LD_READY); end
    LD_ADDR = 2'd3;
    #1;
    checks++; if (LD_READY !== 1'b1) begin errors++; $display("FAIL ld_other_ready got %0b want 1", LD_READY); end
    LD_ADDR = 2'd2;
    tick();
    read_reg(2'd2, v);
    checks++; if (v !== 8'h30) begin errors++; $display("FAIL ld_wb_wins got %02h want 30", v); end
    checks++; if (LD_READY !== 1'b1) begin errors++; $display("FAIL ld_retry_ready got %0b want 1", LD_READY); end
    tick();
    LD_VALID = 1'b0;
    read_reg(2'd2, v);
    checks++; if (v !== 8'hAA) begin errors++; $display("FAIL ld_retry_r2 got %02h want aa", v); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] v;
    drive_req(OP_ADD, 2'd0, 2'd1, 2'd3, 1'b1);
    tick();
    // Now in ISSUE: reset together with a load and a request; reset must win.
    RESET = 1'b1;
    LD_VALID = 1'b1; LD_ADDR = 2'd1; LD_DATA = 8'h55;
    tick();
    RESET = 1'b0; LD_VALID = 1'b0; REQ_VALID = 1'b0;
    #1;
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL abort_done got %0b want 0", DONE); end
    checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL abort_ready got %0b want 1", REQ_READY); end
    checks++; if (ALU_IN_A !== 8'h00 || ALU_OP_CODE !== 4'h0) begin errors++; $display("FAIL abort_alu_if got %02h/%0h want 00/0", ALU_IN_A, ALU_OP_CODE); end
    for (int i = 0; i < 4; i++) begin
      read_reg(i[1:0], v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL abort_reg%0d got %02h want 00", i, v); end
    end
    tick();
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL abort_late_done got %0b want 0", DONE); end
  endtask

  task automatic test_compare();
    logic di, dw; logic [7:0] r;
    logic [3:0]  ops [3] = '{OP_CMPEQ, OP_CMPGT, OP_CMPLT};
    logic [7:0]  exp [3] = '{8'h00, 8'h00, 8'h01};
    do_load(2'd0, 8'h10);
    do_load(2'd1, 8'h20);
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 2'd0, 2'd1, 2'd3, 1'b0, di, dw, r);
      checks++; if (dw !== 1'b1 || r !== exp[i]) begin errors++; $display("FAIL cmp_op%0h got done=%0b %02h want 1 %02h", ops[i], dw, r, exp[i]); end
    end
  endtask

  initial begin
    RESET = 1'b1; REQ_VALID = 1'b0; REQ_OPCODE = '0; REQ_SRC_A = '0; REQ_SRC_B = '0;
    REQ_DST = '0; REQ_WB = 1'b0; LD_VALID = 1'b0; LD_ADDR = '0; LD_DATA = '0; RD_ADDR = '0;
    test_reset();
    test_add();
    test_wrap_and_nowb();
    test_back_to_back();
    test_ld_conflict();
    test_reset_abort();
    test_compare();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
